// File: rtl/apb_pkg.sv
// Shared types and constants for the APB bridge master: bus width defaults,
// FSM state encoding, slave select codes and the code-to-one-hot helper.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    DONE   = 3'd3
  } state_e;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_S1   = 2'd1;
  localparam logic [1:0] SEL_S2   = 2'd2;

  // Reserved and "none" codes map to no select line at all.
  function automatic logic [1:0] sel_onehot(input logic [1:0] code);
    case (code)
      SEL_S1:  return 2'b01;
      SEL_S2:  return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/apb_resp_mux.sv
// Routes pready/prdata of the slave named by the latched select code back to
// the bridge FSM; the other slave's response is ignored.
module apb_resp_mux
  import apb_pkg::*;
#(
  parameter int DATA_W = APB_DATA_W
) (
  input  logic [1:0]        sel_code,
  input  logic              pready1,
  input  logic              pready2,
  input  logic [DATA_W-1:0] prdata1,
  input  logic [DATA_W-1:0] prdata2,
  output logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    rsp_ready = 1'b0;
    rsp_rdata = '0;
    case (sel_code)
      SEL_S1: begin
        rsp_ready = pready1;
        rsp_rdata = prdata1;
      end
      SEL_S2: begin
        rsp_ready = pready2;
        rsp_rdata = prdata2;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/apb_bridge_master.sv
// Processor-request to APB master bridge with two slave selects.
// Optional ACCESS wait timeout and p_error output enabled by APB_TIMEOUT_EN.
module apb_bridge_master
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
`ifdef APB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_start,
  input  logic              p_write,
  input  logic [1:0]        p_sel,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic [DATA_W-1:0] p_rdata,
  output logic              p_stable,
`ifdef APB_TIMEOUT_EN
  output logic              p_error,
`endif
  output logic              presetn,
  output logic [1:0]        psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready1,
  input  logic              pready2,
  input  logic [DATA_W-1:0] prdata1,
  input  logic [DATA_W-1:0] prdata2
);

  state_e              state_q, state_d;
  logic [1:0]          sel_q, sel_d;
  logic [1:0]          psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [DATA_W-1:0]   p_rdata_q, p_rdata_d;
  logic                p_stable_q, p_stable_d;

  logic                rsp_ready;
  logic [DATA_W-1:0]   rsp_rdata;

`ifdef APB_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                p_error_q, p_error_d;
`endif

  apb_resp_mux #(.DATA_W(DATA_W)) u_resp_mux (
    .sel_code  (sel_q),
    .pready1   (pready1),
    .pready2   (pready2),
    .prdata1   (prdata1),
    .prdata2   (prdata2),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    p_rdata_d  = p_rdata_q;
    p_stable_d = 1'b0;
`ifdef APB_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    p_error_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (p_start && (p_sel == SEL_S1 || p_sel == SEL_S2)) begin
          sel_d     = p_sel;
          pwrite_d  = p_write;
          paddr_d   = p_addr;
          pwdata_d  = p_wdata;
          psel_d    = sel_onehot(p_sel);
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ACCESS: begin
        if (rsp_ready) begin
          if (!pwrite_q) p_rdata_d = rsp_rdata;
          psel_d     = 2'b00;
          penable_d  = 1'b0;
          p_stable_d = 1'b1;
          state_d    = DONE;
        end
`ifdef APB_TIMEOUT_EN
        // The wait that reaches the limit ends the transfer without read data.
        else if (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          psel_d     = 2'b00;
          penable_d  = 1'b0;
          p_stable_d = 1'b1;
          p_error_d  = 1'b1;
          state_d    = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sel_q      <= SEL_NONE;
      psel_q     <= 2'b00;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      p_rdata_q  <= '0;
      p_stable_q <= 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q <= '0;
      p_error_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      p_rdata_q  <= p_rdata_d;
      p_stable_q <= p_stable_d;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
      p_error_q  <= p_error_d;
`endif
    end
  end

  assign presetn  = reset;
  assign psel     = psel_q;
  assign penable  = penable_q;
  assign pwrite   = pwrite_q;
  assign paddr    = paddr_q;
  assign pwdata   = pwdata_q;
  assign p_rdata  = p_rdata_q;
  assign p_stable = p_stable_q;
`ifdef APB_TIMEOUT_EN
  assign p_error  = p_error_q;
`endif

endmodule

// File: tb/tb_apb_bridge_master.sv
// Self-checking bench for apb_bridge_master: directed and random transfers
// compared against a transaction-level model of the APB handshake.
module tb_apb_bridge_master;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          p_start, p_write;
  logic [1:0]    p_sel;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;
  logic [DW-1:0] p_rdata;
  logic          p_stable;
  logic          presetn;
  logic [1:0]    psel;
  logic          penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready1, pready2;
  logic [DW-1:0] prdata1, prdata2;
`ifdef APB_TIMEOUT_EN
  logic          p_error;
`endif

  apb_bridge_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .p_start  (p_start),
    .p_write  (p_write),
    .p_sel    (p_sel),
    .p_addr   (p_addr),
    .p_wdata  (p_wdata),
    .p_rdata  (p_rdata),
    .p_stable (p_stable),
`ifdef APB_TIMEOUT_EN
    .p_error  (p_error),
`endif
    .presetn  (presetn),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pready1  (pready1),
    .pready2  (pready2),
    .prdata1  (prdata1),
    .prdata2  (prdata2)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: values of the last accepted request and the last completed read.
  logic [DW-1:0] exp_rdata;
  logic [AW-1:0] exp_addr;
  logic          exp_write;
  logic [DW-1:0] exp_wdata;

  task automatic drive_slaves_random();
    pready1 = 1'($urandom);
    pready2 = 1'($urandom);
    prdata1 = DW'($urandom);
    prdata2 = DW'($urandom);
  endtask

  // One full transfer; 'waits' is the number of ACCESS cycles with pready low.
  task automatic run_xfer(input logic wr, input logic [1:0] sel, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input int waits, input logic [DW-1:0] rd);
    logic [1:0] oh;
    oh = (sel == 2'd1) ? 2'b01 : 2'b10;
    @(negedge clk);
    p_start = 1'b1; p_write = wr; p_sel = sel; p_addr = addr; p_wdata = wdata;
    drive_slaves_random();
    @(negedge clk);
    p_start = 1'b0; p_write = 1'($urandom); p_sel = 2'($urandom);
    p_addr = AW'($urandom); p_wdata = DW'($urandom);
    exp_addr = addr; exp_write = wr; exp_wdata = wdata;
    vectors++;
    if ({psel, penable, p_stable, pwrite, paddr, pwdata} !== {oh, 1'b0, 1'b0, wr, addr, wdata}) begin
      miscompares++;
      $display("FAIL setup: got psel=%b en=%b stb=%b wr=%b a=%h d=%h, want psel=%b en=0 stb=0 wr=%b a=%h d=%h",
               psel, penable, p_stable, pwrite, paddr, pwdata, oh, wr, addr, wdata);
    end
    for (int k = 0; k <= waits; k++) begin
      @(negedge clk);
      vectors++;
      if ({psel, penable, p_stable, pwrite, paddr, pwdata} !== {oh, 1'b1, 1'b0, wr, addr, wdata}) begin
        miscompares++;
        $display("FAIL access[%0d]: got psel=%b en=%b stb=%b wr=%b a=%h d=%h, want psel=%b en=1 stb=0 wr=%b a=%h d=%h",
                 k, psel, penable, p_stable, pwrite, paddr, pwdata, oh, wr, addr, wdata);
      end
      drive_slaves_random();
      if (sel == 2'd1) begin
        pready1 = (k == waits);
        if (k == waits) prdata1 = rd;
      end else begin
        pready2 = (k == waits);
        if (k == waits) prdata2 = rd;
      end
      p_start = 1'($urandom); p_sel = 2'($urandom); p_addr = AW'($urandom);
    end
    @(negedge clk);
    if (!wr) exp_rdata = rd;
    vectors++;
    if ({psel, penable, p_stable, p_rdata} !== {2'b00, 1'b0, 1'b1, exp_rdata}) begin
      miscompares++;
      $display("FAIL done: got psel=%b en=%b stb=%b rdata=%h, want psel=00 en=0 stb=1 rdata=%h",
               psel, penable, p_stable, p_rdata, exp_rdata);
    end
`ifdef APB_TIMEOUT_EN
    vectors++;
    if (p_error !== 1'b0) begin
      miscompares++;
      $display("FAIL done_error: got p_error=%b, want 0", p_error);
    end
`endif
    drive_slaves_random();
    p_start = 1'($urandom); p_sel = 2'($urandom);
    @(negedge clk);
    p_start = 1'b0;
    vectors++;
    if ({psel, penable, p_stable, pwrite, paddr, pwdata, p_rdata} !==
        {2'b00, 1'b0, 1'b0, exp_write, exp_addr, exp_wdata, exp_rdata}) begin
      miscompares++;
      $display("FAIL idle: got psel=%b en=%b stb=%b wr=%b a=%h d=%h rd=%h, want 00/0/0 wr=%b a=%h d=%h rd=%h",
               psel, penable, p_stable, pwrite, paddr, pwdata, p_rdata,
               exp_write, exp_addr, exp_wdata, exp_rdata);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; p_start = 1'b1; p_write = 1'b1; p_sel = 2'd1;
    p_addr = 8'hA5; p_wdata = 8'h5A; drive_slaves_random();
    exp_rdata = '0; exp_addr = '0; exp_write = 1'b0; exp_wdata = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({presetn, psel, penable, p_stable, pwrite, paddr, pwdata, p_rdata} !== {1'b0, 2'b00, 3'b000, 8'h00, 8'h00, 8'h00}) begin
      miscompares++;
      $display("FAIL reset: got presetn=%b psel=%b en=%b stb=%b wr=%b a=%h d=%h rd=%h, want all 0",
               presetn, psel, penable, p_stable, pwrite, paddr, pwdata, p_rdata);
    end
    p_start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({presetn, psel, penable} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_release: got presetn=%b psel=%b en=%b, want 1/00/0", presetn, psel, penable);
    end
  endtask

  task automatic test_ignored_sel(input logic [1:0] sel);
    @(negedge clk);
    p_start = 1'b1; p_sel = sel; p_write = 1'b0; p_addr = AW'($urandom); p_wdata = DW'($urandom);
    @(negedge clk);
    p_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if ({psel, penable, p_stable, paddr, p_rdata} !== {2'b00, 1'b0, 1'b0, exp_addr, exp_rdata}) begin
        miscompares++;
        $display("FAIL ignored_sel%0d[%0d]: got psel=%b en=%b stb=%b a=%h rd=%h, want 00/0/0 a=%h rd=%h",
                 sel, k, psel, penable, p_stable, paddr, p_rdata, exp_addr, exp_rdata);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    p_start = 1'b1; p_write = 1'b0; p_sel = 2'd1; p_addr = 8'h33; p_wdata = 8'h44;
    pready1 = 1'b0; pready2 = 1'b1;
    @(negedge clk);
    p_start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    exp_rdata = '0; exp_addr = '0; exp_write = 1'b0; exp_wdata = '0;
    vectors++;
    if ({presetn, psel, penable, p_stable, paddr, p_rdata} !== {1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_mid: got presetn=%b psel=%b en=%b stb=%b a=%h rd=%h, want all 0",
               presetn, psel, penable, p_stable, paddr, p_rdata);
    end
    @(negedge clk);
    reset = 1'b1;
    run_xfer(1'b0, 2'd1, 8'h21, 8'h00, 1, 8'hC3);
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    logic [DW-1:0] held;
    held = exp_rdata;
    @(negedge clk);
    p_start = 1'b1; p_write = 1'b0; p_sel = 2'd2; p_addr = 8'h77; p_wdata = 8'h00;
    pready1 = 1'b1; pready2 = 1'b0;
    @(negedge clk);
    p_start = 1'b0;
    exp_addr = 8'h77; exp_write = 1'b0; exp_wdata = 8'h00;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      vectors++;
      if ({psel, penable, p_stable} !== 4'b1010) begin
        miscompares++;
        $display("FAIL timeout_wait[%0d]: got psel=%b en=%b stb=%b, want 10/1/0", k, psel, penable, p_stable);
      end
    end
    @(negedge clk);
    vectors++;
    if ({psel, penable, p_stable, p_error, p_rdata} !== {2'b00, 1'b0, 1'b1, 1'b1, held}) begin
      miscompares++;
      $display("FAIL timeout_done: got psel=%b en=%b stb=%b err=%b rd=%h, want 00/0/1/1 rd=%h",
               psel, penable, p_stable, p_error, p_rdata, held);
    end
    pready2 = 1'b1;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    // Write and read without wait states.
    run_xfer(1'b1, 2'd1, 8'h00, 8'h05, 0, 8'h00);
    run_xfer(1'b0, 2'd1, 8'h06, 8'h00, 0, 8'h05);
    // Wait-state handling; the write must not disturb p_rdata.
    run_xfer(1'b1, 2'd1, 8'h05, 8'h04, 5, 8'hEE);
    run_xfer(1'b0, 2'd1, 8'h05, 8'h00, 5, 8'h06);
    run_xfer(1'b0, 2'd1, 8'h04, 8'h00, 1, 8'h07);
    // Slave 2 routing, then the same request with no or reserved select.
    run_xfer(1'b0, 2'd2, 8'h04, 8'h00, 0, 8'h09);
    test_ignored_sel(2'd0);
    test_ignored_sel(2'd3);
    for (int i = 0; i < 30; i++) begin
      run_xfer(1'($urandom), ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd2, AW'($urandom),
               DW'($urandom), $urandom_range(0, 6), DW'($urandom));
    end
    test_reset_mid_access();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_bridge_master.md
Name: apb_bridge_master

Overview:
- Bridges a simple processor request port onto an APB bus with two slave selects.
- The processor pulses a start strobe with address, data, direction and slave code.
- The block runs the APB SETUP/ACCESS sequence, honours slave wait states, and returns read data plus a one-cycle completion flag.
- Sits between the processor-side bus and the APB slaves.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- TIMEOUT_CYCLES, 16, maximum ACCESS wait cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- p_start  in  1  one-cycle request strobe.
- p_write  in  1  1 = write, 0 = read; sampled with p_start.
- p_sel  in  2  slave code: 0 none, 1 slave 1, 2 slave 2, 3 reserved.
- p_addr  in  ADDR_W  transfer address.
- p_wdata  in  DATA_W  write data.
- p_rdata  out  DATA_W  read data of the last completed read.
- p_stable  out  1  one-cycle pulse on transfer completion.
- presetn  out  1  equals reset; forwarded to slaves.
- psel  out  2  one-hot APB select: bit0 slave 1, bit1 slave 2.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pready1, pready2  in  1 each  slave ready signals.
- prdata1, prdata2  in  DATA_W each  slave read data.

Behaviour:
- Reset (reset low, asynchronous): state IDLE; psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, p_rdata=0, p_stable=0.
- States (3-bit encoding): IDLE=0, SETUP=1, ACCESS=2, DONE=3.
- IDLE:
  - On a rising edge with p_start=1 and p_sel equal to 1 or 2: latch p_write, p_addr, p_wdata and p_sel; go to SETUP.
  - p_sel of 0 or 3 with p_start is ignored: no transfer, no p_stable.
  - p_start outside IDLE is ignored (no queueing).
- SETUP: psel = one-hot of the latched code, penable=0, paddr/pwrite/pwdata driven from the latches. Next state is always ACCESS.
- ACCESS: psel held, penable=1.
  - Selected pready=0: remain in ACCESS; all APB outputs stable (wait state).
  - Selected pready=1: transfer completes at that edge. For a read, the selected prdata is captured into p_rdata. Go to DONE.
- DONE: psel=0, penable=0, p_stable=1 for exactly this cycle. Next state is IDLE.
- Latency with zero wait states: start edge, SETUP, ACCESS, DONE. p_stable rises 3 cycles after the start edge. Each wait cycle adds 1.
- The unselected slave's pready and prdata are ignored.
- p_rdata is held until the next completed read; writes do not alter it.
- paddr, pwrite and pwdata hold their last values in IDLE. Only psel/penable return to 0.
- reset asserted mid-transfer aborts immediately to the reset values, with no p_stable.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- When defined: a wait counter runs in ACCESS. If the selected pready stays 0 for TIMEOUT_CYCLES consecutive cycles, the transfer is abandoned and the FSM goes to DONE with p_stable=1. An additional output p_error (1 bit) is 1 during that DONE cycle. p_rdata is unchanged.
- When undefined: no counter and no p_error port. ACCESS waits indefinitely.

Decomposition:
- Package apb_pkg holds:
  - ADDR_W/DATA_W defaults;
  - state enum (IDLE, SETUP, ACCESS, DONE, 3-bit);
  - slave code constants (SEL_NONE=0, SEL_S1=1, SEL_S2=2);
  - a sel-code-to-one-hot function.
- One sub-module is natural: apb_resp_mux. It selects pready/prdata from slave 1 or slave 2 according to the latched code.

Test Plan:
- Write, no wait: pready1=1; p_start with p_write=1, p_sel=1, p_wdata=5, p_addr=0 -> psel=01 with penable=0 for 1 cycle, then penable=1 for 1 cycle, pwdata=5; p_stable pulse 3 cycles after start.
- Read, no wait: p_write=0, p_sel=1, p_addr=6, prdata1=5 -> paddr=6, pwrite=0; p_rdata=5 at p_stable.
- Write with 5 wait states: p_wdata=4, p_addr=5, pready1=0 for 5 ACCESS cycles then 1 -> penable high for 6 cycles; outputs stable throughout; p_stable after pready rises.
- Read with 5 waits, then 1 wait: prdata1=6 when pready=1 -> p_rdata=6. Repeat with p_addr=4, 1 wait, prdata1=7 -> p_rdata=7.
- Slave 2 routing: p_sel=2, prdata2=9, prdata1=3 -> psel=10, p_rdata=9. Same request with p_sel=0 -> no APB activity, no p_stable.
- Reset mid-ACCESS: drop reset while pready1=0 -> psel, penable and p_stable go 0 immediately; after release, a new start works normally.
